demux2_stage: RTL and testbench
===============================

// Module: demux2_stage
// PURPOSE
//  Registered 1-to-2 steering stage: the return direction of the pipeline's registered 2:1 select.
//  Takes one valid/ready input word and routes it to output channel 0 or 1 per CTL.
//  Sits between a producer stage and two consumer stages (e.g. ALU result -> WB / branch unit).
//  Each channel has independent backpressure.
//  Each channel keeps a wrapping count of completed output transfers.
// PARAMETERS
//  WIDTH   32  data width of D, Q0, Q1
//  CNT_W   16  width of per-channel transfer counters CNT0, CNT1
// PORTS
//  CLK        in   1      clock; all state updates on posedge CLK
//  RST        in   1      reset, synchronous, active-high
//  IN_VALID   in   1      input word present
//  IN_READY   out  1      stage accepts input this cycle
//  CTL        in   1      destination: 0 -> channel 0, 1 -> channel 1; sampled only with IN_VALID
//  D          in   WIDTH  input data
//  OUT0_VALID out  1      channel 0 word present
//  OUT0_READY in   1      channel 0 consumer accepts
//  Q0         out  WIDTH  channel 0 data (registered)
//  OUT1_VALID out  1      channel 1 word present
//  OUT1_READY in   1      channel 1 consumer accepts
//  Q1         out  WIDTH  channel 1 data (registered)
//  CNT0       out  CNT_W  channel 0 completed-transfer count
//  CNT1       out  CNT_W  channel 1 completed-transfer count
// BEHAVIOUR
//  - Input transfer (push): IN_VALID && IN_READY at posedge.
//    Output transfer (pop x): OUTx_VALID && OUTx_READY at posedge.
//  - Reset, incl. mid-operation: OUTx_VALID=0, Qx=0, CNTx=0, all buffered words discarded.
//    No pop counted in the reset cycle. IN_READY=1 in the first cycle after reset.
//  - Latency: a word pushed at edge N is on Qx with OUTx_VALID=1 after edge N (1 cycle).
//  - Producer rule: D/CTL held stable while IN_VALID && !IN_READY.
//    CTL/D are don't-care when IN_VALID=0.
//  - Qx holds its value while OUTx_VALID && !OUTx_READY.
//    Qx keeps its last value after pop; it is never cleared except by reset.
//  - Pushing to channel x never changes channel !x's state.
//    Channels pop independently, in the same cycle if both ready.
//  - Push and pop of the same channel in one cycle: Qx takes the new word, OUTx_VALID stays 1.
//  - Per-channel order is preserved. No cross-channel ordering is guaranteed.
//  - CNTx increments by 1 per pop x. It wraps from 2^CNT_W-1 to 0, with no flag.
// CONFIGURATION
//  Macro DEMUX2_SKID_EN.
//  Undefined:
//   - One register per channel.
//   - IN_READY = !OUTsel_VALID || OUTsel_READY, with sel = CTL (combinational path from OUTx_READY).
//  Defined:
//   - Each channel adds a skid register SKx with valid bit SVx.
//   - IN_READY = !SV0 && !SV1. This is registered only (no path from OUTx_READY); head-of-line
//     blocking across channels is accepted.
//   - Push to x: goes to Qx if Qx is empty or popping this cycle, else to SKx (SVx<=1).
//   - Pop x with SVx=1: SKx moves to Qx, SVx<=0, OUTx_VALID stays 1.
//   - A push is impossible while SVx=1, so there is no push/skid conflict.
//   - Reset clears SV0/SV1.
// TESTING
//  1) RST=1 2 cycles then release
//     -> OUT0_VALID=OUT1_VALID=0, CNT0=CNT1=0, IN_READY=1.
//  2) Push D=32'hDEADBEEF CTL=1, OUT1_READY=1
//     -> next cycle Q1=DEADBEEF OUT1_VALID=1.
//     -> CNT1 becomes 1 one edge later; channel 0 untouched.
//  3) OUT0_READY=0, push A0/CTL=0 then A1/CTL=0.
//     -> without SKID_EN: IN_READY=0 on 2nd push, Q0 holds A0.
//     -> with SKID_EN: A1 accepted into skid, IN_READY=0 after.
//     -> raise OUT0_READY: pops A0 then A1 in order, CNT0=2.
//  4) Channel 0 stalled full; push to CTL=1 with OUT1_READY=1
//     -> without SKID_EN: accepted, Q1 updates, Q0 unchanged.
//  5) CNT_W=4, 17 back-to-back pops on channel 0 with continuous push and pop -> CNT0=1 (wrap).
//     -> OUT0_VALID stays 1 throughout.
//  6) Assert RST while both channels are holding words
//     -> next cycle all valids=0, counters=0.
//     -> the word offered in that cycle is not delivered.

Source files
------------

// File: rtl/demux2_stage.sv
// -----------------------------------------------------------------------------
// demux2_stage -- registered 1-to-2 steering stage
//
// Accepts one valid/ready word and routes it to output channel 0 or 1 as
// selected by ctl_i. Each channel has its own output register, its own
// backpressure and a wrapping count of completed output transfers.
//
// Optional feature macro: DEMUX2_SKID_EN
//   undefined : one register per channel; in_ready_o is combinational from
//               the selected channel's out*_ready_i.
//   defined   : each channel adds one skid register; in_ready_o depends only
//               on the skid valid bits (fully registered). A skid in use on
//               either channel blocks all input (head-of-line blocking).
//
// Parameters
//   WIDTH  data width of d_i, q0_o, q1_o
//   CNT_W  width of the per-channel transfer counters
//
// Ports
//   clk_i          clock, all state updates on rising edge
//   rst_i          synchronous active-high reset
//   in_valid_i     input word present
//   in_ready_o     stage accepts input this cycle
//   ctl_i          destination channel (sampled only with in_valid_i)
//   d_i            input data
//   out0_valid_o   channel 0 word present
//   out0_ready_i   channel 0 consumer accepts
//   q0_o           channel 0 data (registered)
//   out1_valid_o   channel 1 word present
//   out1_ready_i   channel 1 consumer accepts
//   q1_o           channel 1 data (registered)
//   cnt0_o         channel 0 completed-transfer count (wraps)
//   cnt1_o         channel 1 completed-transfer count (wraps)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// demux2_lane -- one output channel: output register, optional skid register
// and transfer counter.
//
// Ports
//   clk_i, rst_i   clock / synchronous active-high reset
//   push_i         a word is written into this lane this cycle
//   d_i            word to write
//   out_ready_i    consumer accepts
//   out_valid_o    output register holds a word
//   q_o            output register
//   cnt_o          completed pop count
//   accept_o       lane can take a push this cycle
//                  (no skid: register empty or draining now;
//                   skid:    skid register empty)
// -----------------------------------------------------------------------------
module demux2_lane #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] q_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             accept_o
);

   logic             vld_q, vld_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop;

   assign pop = vld_q && out_ready_i;

`ifdef DEMUX2_SKID_EN
   logic             sv_q, sv_d;
   logic [WIDTH-1:0] sk_q, sk_d;

   // Only the skid state gates input, so accept has no path from out_ready_i.
   assign accept_o = !sv_q;

   always_comb begin
      vld_d = vld_q;
      q_d   = q_q;
      sv_d  = sv_q;
      sk_d  = sk_q;
      if (pop && sv_q) begin
         // Skid drains into the output register; output stays valid.
         // A push cannot coincide because accept_o is low while sv_q is set.
         q_d  = sk_q;
         sv_d = 1'b0;
      end else if (push_i) begin
         if (!vld_q || pop) begin
            q_d   = d_i;
            vld_d = 1'b1;
         end else begin
            sk_d = d_i;
            sv_d = 1'b1;
         end
      end else if (pop) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sv_q <= 1'b0;
         sk_q <= '0;
      end else begin
         sv_q <= sv_d;
         sk_q <= sk_d;
      end
   end
`else
   // Single register: a push is allowed when empty or when the current word
   // leaves this same cycle.
   assign accept_o = !vld_q || out_ready_i;

   always_comb begin
      vld_d = vld_q;
      q_d   = q_q;
      if (push_i) begin
         q_d   = d_i;
         vld_d = 1'b1;
      end else if (pop) begin
         vld_d = 1'b0;
      end
   end
`endif

   // Counter wraps naturally at 2^CNT_W.
   assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pop};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= 1'b0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_valid_o = vld_q;
   assign q_o         = q_q;
   assign cnt_o       = cnt_q;

endmodule

// -----------------------------------------------------------------------------
// demux2_stage -- top: two lanes plus input steering
// -----------------------------------------------------------------------------
module demux2_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             ctl_i,
   input  logic [WIDTH-1:0] d_i,
   output logic             out0_valid_o,
   input  logic             out0_ready_i,
   output logic [WIDTH-1:0] q0_o,
   output logic             out1_valid_o,
   input  logic             out1_ready_i,
   output logic [WIDTH-1:0] q1_o,
   output logic [CNT_W-1:0] cnt0_o,
   output logic [CNT_W-1:0] cnt1_o
);

   localparam int NUM_CH = 2;

   logic [NUM_CH-1:0]            push;
   logic [NUM_CH-1:0]            rdy;
   logic [NUM_CH-1:0]            vld;
   logic [NUM_CH-1:0]            accept;
   logic [NUM_CH-1:0][WIDTH-1:0] q;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt;
   logic                         xfer_in;

   assign rdy = {out1_ready_i, out0_ready_i};

`ifdef DEMUX2_SKID_EN
   // Any occupied skid stalls the input regardless of destination.
   assign in_ready_o = &accept;
`else
   assign in_ready_o = accept[ctl_i];
`endif

   assign xfer_in = in_valid_i && in_ready_o;
   assign push[0] = xfer_in && !ctl_i;
   assign push[1] = xfer_in &&  ctl_i;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      demux2_lane #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_lane (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .push_i      (push[g]),
         .d_i         (d_i),
         .out_ready_i (rdy[g]),
         .out_valid_o (vld[g]),
         .q_o         (q[g]),
         .cnt_o       (cnt[g]),
         .accept_o    (accept[g])
      );
   end

   assign out0_valid_o = vld[0];
   assign out1_valid_o = vld[1];
   assign q0_o         = q[0];
   assign q1_o         = q[1];
   assign cnt0_o       = cnt[0];
   assign cnt1_o       = cnt[1];

endmodule

// File: tb/tb_demux2_stage.sv
// -----------------------------------------------------------------------------
// tb_demux2_stage -- directed and randomized bench for demux2_stage.
// The reference model keeps one queue of pending words per channel; the head
// of a non-empty queue is what the channel shows, and the last popped word is
// what it keeps showing once empty. Counters use CNT_W=4 so wrap is reachable.
// -----------------------------------------------------------------------------
module tb_demux2_stage;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
   localparam int CMOD  = 1 << CNT_W;
`ifdef DEMUX2_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             ctl = 1'b0;
   logic [WIDTH-1:0] d = '0;
   logic             out0_valid, out1_valid;
   logic             out0_ready = 1'b0, out1_ready = 1'b0;
   logic [WIDTH-1:0] q0, q1;
   logic [CNT_W-1:0] cnt0, cnt1;

   always #5 clk = ~clk;

   demux2_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .ctl_i        (ctl),
      .d_i          (d),
      .out0_valid_o (out0_valid),
      .out0_ready_i (out0_ready),
      .q0_o         (q0),
      .out1_valid_o (out1_valid),
      .out1_ready_i (out1_ready),
      .q1_o         (q1),
      .cnt0_o       (cnt0),
      .cnt1_o       (cnt1)
   );

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // reference model
   logic [WIDTH-1:0] mq [2][$];
   logic [WIDTH-1:0] lastq [2];
   int               mcnt [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
      end
   endtask

   function automatic bit m_ready(input bit c, input bit r0, input bit r1);
`ifdef DEMUX2_SKID_EN
      return (mq[0].size() < DEPTH) && (mq[1].size() < DEPTH);
`else
      return (mq[c].size() == 0) || (c ? r1 : r0);
`endif
   endfunction

   function automatic logic [WIDTH-1:0] m_q(input int x);
      return (mq[x].size() > 0) ? mq[x][0] : lastq[x];
   endfunction

   // One clock: drive inputs after the falling edge, compare just after,
   // then advance the model across the rising edge.
   task automatic cycle(input bit r, input bit iv, input bit c, input logic [WIDTH-1:0] dd,
                        input bit r0, input bit r1, input bit do_chk, output bit acc);
      bit p0, p1, er;
      @(negedge clk);
      rst = r; in_valid = iv; ctl = c; d = dd; out0_ready = r0; out1_ready = r1;
      #1;
      cyc_n++;
      er = m_ready(c, r0, r1);
      if (do_chk) begin
         chk("in_ready",   64'(in_ready),   64'(er));
         chk("out0_valid", 64'(out0_valid), 64'(mq[0].size() > 0));
         chk("out1_valid", 64'(out1_valid), 64'(mq[1].size() > 0));
         chk("q0",         64'(q0),         64'(m_q(0)));
         chk("q1",         64'(q1),         64'(m_q(1)));
         chk("cnt0",       64'(cnt0),       64'(mcnt[0]));
         chk("cnt1",       64'(cnt1),       64'(mcnt[1]));
      end
      acc = iv && er && !r;
      p0  = (mq[0].size() > 0) && r0;
      p1  = (mq[1].size() > 0) && r1;
      @(posedge clk);
      if (r) begin
         mq[0].delete(); mq[1].delete();
         lastq[0] = '0; lastq[1] = '0;
         mcnt[0] = 0; mcnt[1] = 0;
      end else begin
         if (p0) begin lastq[0] = mq[0].pop_front(); mcnt[0] = (mcnt[0] + 1) % CMOD; end
         if (p1) begin lastq[1] = mq[1].pop_front(); mcnt[1] = (mcnt[1] + 1) % CMOD; end
         if (acc) mq[c].push_back(dd);
      end
   endtask

   initial begin
      bit acc;
      bit hold;
      bit hc;
      logic [WIDTH-1:0] hd;
      lastq[0] = '0; lastq[1] = '0; mcnt[0] = 0; mcnt[1] = 0;

      // 1) reset two cycles
      cycle(1, 0, 0, '0, 0, 0, 0, acc);
      cycle(1, 0, 0, '0, 0, 0, 1, acc);
      cycle(0, 0, 0, '0, 0, 0, 1, acc);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_cnt0", 64'(cnt0), 64'd0);

      // 2) push to channel 1
      cycle(0, 1, 1, 32'hDEADBEEF, 0, 1, 1, acc);
      #1;
      chk("t2_q1",   64'(q1), 64'hDEADBEEF);
      chk("t2_v1",   64'(out1_valid), 64'd1);
      chk("t2_v0",   64'(out0_valid), 64'd0);
      chk("t2_cnt1", 64'(cnt1), 64'd0);
      cycle(0, 0, 0, '0, 0, 1, 1, acc);
      #1;
      chk("t2_cnt1_pop", 64'(cnt1), 64'd1);
      chk("t2_cnt0", 64'(cnt0), 64'd0);

      // 3) stall channel 0 with two words
      cycle(0, 1, 0, 32'hA0A0_0000, 0, 0, 1, acc);
      cycle(0, 1, 0, 32'hA1A1_0001, 0, 0, 1, acc);
`ifdef DEMUX2_SKID_EN
      #1;
      chk("t3_skid_acc", 64'(acc), 64'd1);
      chk("t3_in_ready", 64'(in_ready), 64'd0);
      chk("t3_q0_hold",  64'(q0), 64'hA0A0_0000);
      cycle(0, 0, 0, '0, 1, 0, 1, acc);
`else
      cycle(0, 1, 0, 32'hA1A1_0001, 0, 0, 1, acc);
      #1;
      chk("t3_in_ready", 64'(in_ready), 64'd0);
      chk("t3_q0_hold",  64'(q0), 64'hA0A0_0000);
      cycle(0, 1, 0, 32'hA1A1_0001, 1, 0, 1, acc);
`endif
      #1;
      chk("t3_q0_a1", 64'(q0), 64'hA1A1_0001);
      chk("t3_v0",    64'(out0_valid), 64'd1);
      chk("t3_cnt0_1", 64'(cnt0), 64'd1);
      cycle(0, 0, 0, '0, 1, 0, 1, acc);
      #1;
      chk("t3_cnt0_2", 64'(cnt0), 64'd2);
      chk("t3_v0_empty", 64'(out0_valid), 64'd0);
      chk("t3_q0_keep", 64'(q0), 64'hA1A1_0001);

      // 4) channel 0 full and stalled, channel 1 still accepts
      cycle(0, 1, 0, 32'hA2A2_0002, 0, 0, 1, acc);
      cycle(0, 1, 1, 32'hB0B0_1000, 0, 1, 1, acc);
      #1;
      chk("t4_acc", 64'(acc), 64'd1);
      chk("t4_q1",  64'(q1), 64'hB0B0_1000);
      chk("t4_q0",  64'(q0), 64'hA2A2_0002);
      chk("t4_v0",  64'(out0_valid), 64'd1);
      cycle(0, 0, 0, '0, 1, 1, 1, acc);

      // 5) counter wrap: 17 pops with continuous push and pop
      cycle(1, 0, 0, '0, 0, 0, 1, acc);
      cycle(0, 1, 0, 32'h5000_0000, 1, 0, 1, acc);
      for (int i = 1; i <= 17; i++) begin
         cycle(0, 1, 0, 32'h5000_0000 + 32'(i), 1, 0, 1, acc);
         #1;
         chk("t5_v0", 64'(out0_valid), 64'd1);
      end
      chk("t5_wrap", 64'(cnt0), 64'd1);

      // 6) reset while both channels hold words
      cycle(0, 1, 1, 32'hC0C0_C0C0, 0, 0, 1, acc);
      cycle(1, 1, 0, 32'hE0E0_E0E0, 1, 1, 1, acc);
      #1;
      chk("t6_v0", 64'(out0_valid), 64'd0);
      chk("t6_v1", 64'(out1_valid), 64'd0);
      chk("t6_c0", 64'(cnt0), 64'd0);
      chk("t6_c1", 64'(cnt1), 64'd0);
      chk("t6_q0", 64'(q0), 64'd0);
      chk("t6_ir", 64'(in_ready), 64'd1);
      cycle(0, 0, 0, '0, 1, 1, 1, acc);
      #1;
      chk("t6_no_deliver", 64'(out0_valid), 64'd0);

      // 7) randomized traffic with producer hold rule and occasional reset
      hold = 0; hc = 0; hd = '0;
      for (int i = 0; i < 400; i++) begin
         bit r, iv, c;
         logic [WIDTH-1:0] dd;
         r  = ($urandom_range(0, 59) == 0);
         if (hold) begin iv = 1; c = hc; dd = hd; end
         else begin iv = ($urandom_range(0, 3) != 0); c = 1'($urandom); dd = $urandom; end
         cycle(r, iv, c, dd, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), 1, acc);
         hold = iv && !acc && !r;
         hc = c; hd = dd;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
